// File: rtl/conv_window_buffer.sv
// Sliding KxK window generator over a raster pixel stream, backed by a K-row circular line buffer.
// Optional consumer backpressure (out_ready port) is compiled in with CONV_WIN_READY_EN.
module conv_window_buffer #(
  parameter int unsigned IMG_W     = 28,
  parameter int unsigned IMG_H     = 28,
  parameter int unsigned K         = 5,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STRIDE    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
`ifdef CONV_WIN_READY_EN
  input  logic                       out_ready,
`endif
  output logic                       out_valid,
  output logic [K*K*DATA_BITS-1:0]   win_out,
  output logic [7:0]                 out_row,
  output logic [7:0]                 out_col,
  output logic                       frame_done
);

  localparam int unsigned Depth = K * IMG_W;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned WinW  = K * K * DATA_BITS;
  localparam int unsigned LastY = (K - 1) + ((IMG_H - K) / STRIDE) * STRIDE;
  localparam int unsigned LastX = (K - 1) + ((IMG_W - K) / STRIDE) * STRIDE;

  logic out_ready_w;
`ifdef CONV_WIN_READY_EN
  assign out_ready_w = out_ready;
`else
  assign out_ready_w = 1'b1;
`endif

  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [7:0]           col_q, col_d, row_q, row_d;
  logic [2:0]           slot_q, slot_d;
  logic                 out_valid_q, out_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic [7:0]           out_row_q, out_row_d, out_col_q, out_col_d;
  logic [WinW-1:0]      win_q, win_d;
  logic [7:0]           row_off, col_off;
  logic                 row_hit, col_hit, qual, accept;
  logic [AddrW-1:0]     wr_addr;

  assign in_ready = rst | ~(out_valid_q & ~out_ready_w);
  assign accept   = in_valid & in_ready;
  assign wr_addr  = AddrW'(32'(slot_q) * IMG_W + 32'(col_q));

  assign row_off = row_q - 8'(K - 1);
  assign col_off = col_q - 8'(K - 1);
  assign row_hit = (row_q >= 8'(K - 1)) && ((STRIDE == 1) || !row_off[0]);
  assign col_hit = (col_q >= 8'(K - 1)) && ((STRIDE == 1) || !col_off[0]);
  assign qual    = row_hit & col_hit;

  // Window row r sits in slot (current_slot + 1 + r) mod K; r = K-1 is the current row.
  function automatic logic [AddrW-1:0] rd_addr(input logic [2:0] slot, input logic [7:0] col,
                                               input int unsigned r, input int unsigned c);
    int unsigned s, x;
    s = 32'(slot) + 1 + r;
    if (s >= K) s = s - K;
    x = 32'(col) + c - (K - 1);
    if (x >= IMG_W) x = 0;
    return AddrW'(s * IMG_W + x);
  endfunction

  always_comb begin
    win_d = '0;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        if (r == K - 1 && c == K - 1) begin
          win_d[(r*K+c)*DATA_BITS +: DATA_BITS] = in_data;
        end else begin
          win_d[(r*K+c)*DATA_BITS +: DATA_BITS] = mem_q[rd_addr(slot_q, col_q, r, c)];
        end
      end
    end
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    slot_d       = slot_q;
    out_valid_d  = out_valid_q;
    frame_done_d = frame_done_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    if (accept) begin
      if (col_q == 8'(IMG_W - 1)) begin
        col_d = '0;
        if (row_q == 8'(IMG_H - 1)) begin
          row_d  = '0;
          slot_d = '0;
        end else begin
          row_d  = row_q + 8'd1;
          slot_d = (slot_q == 3'(K - 1)) ? 3'd0 : slot_q + 3'd1;
        end
      end else begin
        col_d = col_q + 8'd1;
      end
      out_valid_d  = qual;
      frame_done_d = qual && (row_q == 8'(LastY)) && (col_q == 8'(LastX));
      if (qual) begin
        out_row_d = row_off;
        out_col_d = col_off;
      end
    end else if (out_ready_w) begin
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      slot_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_q        <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      slot_q       <= slot_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      if (accept && qual) win_q <= win_d;
    end
  end

  // Line buffer is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_addr] <= in_data;
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign win_out    = win_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: 6x6 image, K=3, stride-1 and stride-2 instances on one stream,
// scoreboarded against an image-array model; backpressure steps enabled with CONV_WIN_READY_EN.
module tb_conv_window_buffer;

  typedef struct packed {
    logic [71:0] win;
    logic [7:0]  row;
    logic [7:0]  col;
    logic        fd;
  } exp_t;

  logic        clk, rst, in_valid, rdy_a, rdy_b;
  logic [7:0]  in_data;
  logic        in_ready_a, out_valid_a, fd_a, in_ready_b, out_valid_b, fd_b;
  logic [71:0] win_a, win_b;
  logic [7:0]  row_a, col_a, row_b, col_b;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  img [2][36];
  int          ym [2];
  int          xm [2];
  int          cnt [2];
  logic        acc [2];
  exp_t        qa [$];
  exp_t        qb [$];
  logic [16:0] log_a [$];
  logic [16:0] log_b [$];

  conv_window_buffer #(.IMG_W(6), .IMG_H(6), .K(3), .DATA_BITS(8), .STRIDE(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
`ifdef CONV_WIN_READY_EN
    .out_ready(rdy_a),
`endif
    .out_valid(out_valid_a), .win_out(win_a), .out_row(row_a), .out_col(col_a),
    .frame_done(fd_a)
  );

  conv_window_buffer #(.IMG_W(6), .IMG_H(6), .K(3), .DATA_BITS(8), .STRIDE(2)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
`ifdef CONV_WIN_READY_EN
    .out_ready(rdy_b),
`endif
    .out_valid(out_valid_b), .win_out(win_b), .out_row(row_b), .out_col(col_b),
    .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window whose top-left pixel is (y0,x0) in an image where pixel = y*6+x.
  function automatic logic [71:0] mkwin(input int y0, input int x0);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[(r*3+c)*8 +: 8] = 8'((y0 + r) * 6 + x0 + c);
    return w;
  endfunction

  function automatic logic [71:0] model_win(input int d, input int y, input int x);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) w[(r*3+c)*8 +: 8] = img[d][(y - 2 + r) * 6 + (x - 2 + c)];
    return w;
  endfunction

  task automatic mon(input int d, input int s, input logic ir, input logic ov, input logic rdy,
                     input logic [71:0] w, input logic [7:0] r, input logic [7:0] c,
                     input logic fd);
    exp_t e;
    int   n;
    int   last;
    n = (d == 0) ? qa.size() : qb.size();
    chk($sformatf("valid_vs_model%0d", d), 72'(ov), 72'(n != 0));
    if (ov && rdy && n != 0) begin
      e = (d == 0) ? qa.pop_front() : qb.pop_front();
      chk($sformatf("win%0d", d), w, e.win);
      chk($sformatf("row%0d", d), 72'(r), 72'(e.row));
      chk($sformatf("col%0d", d), 72'(c), 72'(e.col));
      chk($sformatf("fd%0d", d), 72'(fd), 72'(e.fd));
      if (d == 0) log_a.push_back({fd, r, c});
      else        log_b.push_back({fd, r, c});
      cnt[d]++;
      if (e.fd) begin
        chk($sformatf("frame_count%0d", d), 72'(cnt[d]), 72'((d == 0) ? 16 : 4));
        cnt[d] = 0;
      end
    end
    acc[d] = in_valid && ir && !rst;
    last = 2 + (3 / s) * s;
    if (rst) begin
      if (d == 0) qa.delete(); else qb.delete();
      ym[d] = 0; xm[d] = 0; cnt[d] = 0;
    end else if (acc[d]) begin
      img[d][ym[d] * 6 + xm[d]] = in_data;
      if (ym[d] >= 2 && xm[d] >= 2 && (ym[d] - 2) % s == 0 && (xm[d] - 2) % s == 0) begin
        e.win = model_win(d, ym[d], xm[d]);
        e.row = 8'(ym[d] - 2);
        e.col = 8'(xm[d] - 2);
        e.fd  = (ym[d] == last) && (xm[d] == last);
        if (d == 0) qa.push_back(e); else qb.push_back(e);
      end
      if (xm[d] == 5) begin
        xm[d] = 0;
        ym[d] = (ym[d] == 5) ? 0 : ym[d] + 1;
      end else begin
        xm[d] = xm[d] + 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon(0, 1, in_ready_a, out_valid_a, rdy_a, win_a, row_a, col_a, fd_a);
    mon(1, 2, in_ready_b, out_valid_b, rdy_b, win_b, row_b, col_b, fd_b);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!(acc[0] && acc[1]) && n < 20);
    chk("send_accept", 72'(acc[0] && acc[1]), 72'(1));
    in_valid = 1'b0;
  endtask

  task automatic sendg(input logic [7:0] d, input bit gap);
    send(d);
    if (gap && $urandom_range(1, 0) == 1) step();
  endtask

  task automatic ref_frame();
    for (int p = 0; p < 36; p++) begin
      send(8'(p));
      if (p == 13) begin
        chk("pre_first_valid_a", 72'(out_valid_a), 72'(0));
        chk("pre_first_valid_b", 72'(out_valid_b), 72'(0));
      end
      if (p == 14) begin
        chk("first_valid_a", 72'(out_valid_a), 72'(1));
        chk("first_win_a", win_a, mkwin(0, 0));
        chk("first_row_a", 72'(row_a), 72'(0));
        chk("first_col_a", 72'(col_a), 72'(0));
        chk("first_fd_a", 72'(fd_a), 72'(0));
        chk("first_valid_b", 72'(out_valid_b), 72'(1));
      end
      if (p == 28) begin
        chk("last_fd_b", 72'(fd_b), 72'(1));
        chk("last_row_b", 72'(row_b), 72'(2));
        chk("last_col_b", 72'(col_b), 72'(2));
        chk("last_win_b", win_b, mkwin(2, 2));
      end
      if (p == 35) begin
        chk("last_fd_a", 72'(fd_a), 72'(1));
        chk("last_row_a", 72'(row_a), 72'(3));
        chk("last_col_a", 72'(col_a), 72'(3));
        chk("last_win_a", win_a, mkwin(3, 3));
      end
    end
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; rdy_a = 1'b1; rdy_b = 1'b1;
    for (int d = 0; d < 2; d++) begin ym[d] = 0; xm[d] = 0; cnt[d] = 0; acc[d] = 1'b0; end
    repeat (3) step();
    chk("rst_valid_a", 72'(out_valid_a), 72'(0));
    chk("rst_win_a", win_a, 72'(0));
    chk("rst_row_a", 72'(row_a), 72'(0));
    chk("rst_col_a", 72'(col_a), 72'(0));
    chk("rst_fd_a", 72'(fd_a), 72'(0));
    chk("rst_ready_a", 72'(in_ready_a), 72'(1));
    chk("rst_valid_b", 72'(out_valid_b), 72'(0));
    chk("rst_ready_b", 72'(in_ready_b), 72'(1));
    rst = 1'b0;
    step();

    ref_frame();
    chk("frame0_count_a", 72'(log_a.size()), 72'(16));
    chk("frame0_count_b", 72'(log_b.size()), 72'(4));
    if (log_b.size() == 4) begin
      chk("s2_win0", 72'(log_b[0]), 72'({1'b0, 8'd0, 8'd0}));
      chk("s2_win1", 72'(log_b[1]), 72'({1'b0, 8'd0, 8'd2}));
      chk("s2_win2", 72'(log_b[2]), 72'({1'b0, 8'd2, 8'd0}));
      chk("s2_win3", 72'(log_b[3]), 72'({1'b1, 8'd2, 8'd2}));
    end
    log_a.delete(); log_b.delete();

    for (int p = 0; p < 15; p++) send(8'(p));
`ifdef CONV_WIN_READY_EN
    rdy_a = 1'b0;
    repeat (5) begin
      step();
      chk("stall_in_ready", 72'(in_ready_a), 72'(0));
      chk("stall_valid", 72'(out_valid_a), 72'(1));
      chk("stall_win", win_a, mkwin(0, 0));
      chk("stall_row", 72'(row_a), 72'(0));
      chk("stall_col", 72'(col_a), 72'(0));
      chk("stall_fd", 72'(fd_a), 72'(0));
    end
    rdy_a = 1'b1;
`endif
    send(8'd15);
    chk("second_valid_a", 72'(out_valid_a), 72'(1));
    chk("second_win_a", win_a, mkwin(0, 1));
    chk("second_col_a", 72'(col_a), 72'(1));
    for (int p = 16; p < 36; p++) sendg(8'(p), 1'b1);
    for (int p = 0; p < 36; p++) sendg(8'(p), 1'b1);
    step();
    step();
    chk("gap_count_a", 72'(log_a.size()), 72'(32));
    chk("gap_count_b", 72'(log_b.size()), 72'(8));
    log_a.delete(); log_b.delete();

    for (int p = 0; p < 36; p++) sendg(8'($urandom), 1'b1);
    step();
    step();
    chk("rand_count_a", 72'(log_a.size()), 72'(16));
    chk("rand_count_b", 72'(log_b.size()), 72'(4));

    for (int p = 0; p < 21; p++) send(8'(p));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid_a", 72'(out_valid_a), 72'(0));
    chk("midrst_ready_a", 72'(in_ready_a), 72'(1));
    log_a.delete(); log_b.delete();
    ref_frame();
    chk("postrst_count_a", 72'(log_a.size()), 72'(16));
    chk("postrst_count_b", 72'(log_b.size()), 72'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
